tlb_unit: RTL and testbench
===========================

# tlb_unit

Fully associative joint TLB for the MIPS pipeline, directly downstream of the CP0 register file. It consumes CP0 EntryHi/EntryLo0/EntryLo1/PageMask/Index/Random and executes TLBWI/TLBWR writes. It returns TLBP/TLBR results back to CP0 in the same cycle. It also translates one instruction-fetch address and one data address per cycle, flagging refill, invalid and modify exceptions.

## Interface
- TLB_LINE_NUM, 16: number of entries; power of two, 2..32; IDX_W = log2(TLB_LINE_NUM).
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stallM  in  1  MEM stall; suppresses TLB writes and micro-TLB updates
- tlb_typeM  in  4  {tlbwr, tlbwi, tlbr, tlbp}; at most one bit set
- entry_hi_W, page_mask_W, entry_lo0_W, entry_lo1_W, index_W, random_W  in  32 each  current CP0 registers
- k0  in  3  Config.K0; kseg0 is cached iff k0==3
- index_in  out  32  TLBP result: bit31 = P (no match), [IDX_W-1:0] = matching index, other bits 0
- entry_hi_in, page_mask_in, entry_lo0_in, entry_lo1_in  out  32 each  TLBR result for entry index_W[IDX_W-1:0]
- inst_vaddr  in  32 ; inst_paddr  out  32 ; inst_refill, inst_invalid, inst_uncached  out  1 each
- inst_tlb_stall  out  1  fetch must hold (micro-TLB fill cycle)
- data_vaddr  in  32 ; data_wen  in  1 (store) ; data_paddr  out  32 ; data_refill, data_invalid, data_modified, data_uncached  out  1 each

## Operation
- Field layout: EntryHi VPN2 [31:13], ASID [7:0]. PageMask MASK [24:13]. EntryLo PFN [25:6], C [5:3], D [2], V [1], G [0].
- Each entry stores VPN2, ASID, MASK, G, and per-page {PFN, C, D, V}.
- On write, the stored G = lo0.G & lo1.G.
- Write: tlbwi writes entry index_W[IDX_W-1:0]; tlbwr writes entry random_W[IDX_W-1:0]. The write is committed at posedge when the bit is set and stallM=0.
- Match (entry i vs vaddr): VPN2 bits equal where MASK=0, and (G or ASID == entry_hi_W[7:0]). MASK bit k masks VPN2 bit k.
- Odd/even select: vaddr bit (12 + popcount(MASK)); MASK is contiguous from bit 13.
- paddr = {PFN,12'b0} with offset bits below the page size taken from vaddr.
- Multiple matches: the lowest index wins. This rule is deterministic.
- Unmapped regions:
  - kseg0 (vaddr[31:29]=100) and kseg1 (101): paddr = {3'b0, vaddr[28:0]}, no exceptions.
  - kseg1 is always uncached.
  - kseg0 is uncached iff k0!=3.
- Mapped regions (kuseg, kseg2/3):
  - refill = no match.
  - invalid = match & V=0.
  - data_modified = match & V & ~D & data_wen.
  - uncached = C!=3.
  - On any exception flag, paddr = 0.
  - Flags are mutually exclusive, priority refill > invalid > modified.
- TLBP: matches entry_hi_W VPN2/ASID using the same rules.
- TLBR: outputs stored fields. entry_hi_in = {VPN2,5'b0,ASID}. EntryLo G bits = stored G. Unused bits are 0.
- Reset: all entries cleared to 0 (V=0, G=0, so every mapped lookup with ASID≠0 or any lookup refills/invalids deterministically).

## Timing
- All translation, TLBP and TLBR outputs are combinational from the current entry array and inputs. CP0 latches TLBP/TLBR results at the same edge.
- A write takes effect from the next cycle. Same-cycle lookups and TLBP/TLBR observe the old contents.
- tlbwi/tlbwr with stallM=1: no write; the operation repeats when the stall releases.
- Reset values: index_in = 32'h8000_0000 (empty array, no match). TLBR outputs are 0. inst_tlb_stall = 0. Translation outputs follow the unmapped/refill rules above.

## Configuration
- ITLB_MICRO_EN defined: a one-entry instruction micro-TLB is placed in front of the fetch port.
  - State: valid, VPN (vaddr[31:12]), ASID, PFN, uncached.
  - Unmapped fetches bypass the micro-TLB.
  - Mapped hit (valid, vaddr[31:12] and ASID equal): the translation is returned combinationally, with inst_tlb_stall=0.
  - Mapped miss: inst_tlb_stall=1 for exactly one cycle. On that edge (stallM ignored), the main-array result is latched into the micro-TLB if it has no exception. The next cycle serves from the micro-TLB.
  - Exceptions on the miss cycle are reported in the following cycle from a latched copy, with no fill.
  - valid is cleared on rst and on any committed tlbwi/tlbwr. ASID change misses naturally.
- Not defined: the fetch port is purely combinational from the main array, and inst_tlb_stall is tied 0.

## Test plan
- Reset, then data_vaddr=0x0040_0000, ASID 0 -> data_invalid=0, data_refill=1, paddr 0. Also inst_vaddr=0xBFC0_0000 -> paddr 0x1FC0_0000, uncached=1.
- tlbwi entry 3 (VPN2=0x00200, ASID 5, lo0 PFN=0x100 V=1 D=1 C=3, lo1 V=0). Next cycle with ASID 5:
  - 0x0040_0123 -> paddr 0x0010_0123.
  - 0x0040_1000 -> data_invalid.
- Same entry with D=0 and data_wen=1 -> data_modified=1. ASID changed to 6, G=0 -> data_refill=1.
- tlbp with a matching EntryHi -> index_in=3. With a non-matching EntryHi -> index_in=0x8000_0000. tlbr index 3 -> fields read back as written.
- tlbwr with random_W=7 while stallM=1 for two cycles -> entry 7 written only on the first unstalled edge. A lookup in the write cycle still sees the old entry.
- ITLB_MICRO_EN: first fetch to a mapped page -> inst_tlb_stall=1 for one cycle, then a hit with stall 0. A tlbwi -> the next fetch stalls again.

Source files
------------

// File: rtl/tlb_unit.sv
// Fully associative joint TLB: TLBWI/TLBWR/TLBP/TLBR plus one fetch and one data translation per cycle.
// Optional ITLB_MICRO_EN places a one-entry instruction micro-TLB in front of the fetch port.
module tlb_unit #(
    parameter int TLB_LINE_NUM = 16,
    localparam int IDX_W = $clog2(TLB_LINE_NUM)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallM,
    input  logic [3:0]  tlb_typeM,
    input  logic [31:0] entry_hi_W,
    input  logic [31:0] page_mask_W,
    input  logic [31:0] entry_lo0_W,
    input  logic [31:0] entry_lo1_W,
    input  logic [31:0] index_W,
    input  logic [31:0] random_W,
    input  logic [2:0]  k0,
    output logic [31:0] index_in,
    output logic [31:0] entry_hi_in,
    output logic [31:0] page_mask_in,
    output logic [31:0] entry_lo0_in,
    output logic [31:0] entry_lo1_in,
    input  logic [31:0] inst_vaddr,
    output logic [31:0] inst_paddr,
    output logic        inst_refill,
    output logic        inst_invalid,
    output logic        inst_uncached,
    output logic        inst_tlb_stall,
    input  logic [31:0] data_vaddr,
    input  logic        data_wen,
    output logic [31:0] data_paddr,
    output logic        data_refill,
    output logic        data_invalid,
    output logic        data_modified,
    output logic        data_uncached
);
    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic [11:0] mask;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    typedef struct packed {
        logic [31:0] paddr;
        logic [2:0]  c;
        logic        d;
        logic        v;
    } xlt_t;

    typedef struct packed {
        logic [31:0] paddr;
        logic        refill;
        logic        invalid;
        logic        modified;
        logic        uncached;
    } port_t;

    function automatic logic entry_match(input logic [18:0] vpn2, input logic [11:0] mask,
                                         input logic g, input logic [7:0] asid,
                                         input logic [18:0] va_vpn2, input logic [7:0] cur_asid);
        return (((vpn2 ^ va_vpn2) & ~{7'b0, mask}) == 19'b0) && (g || (asid == cur_asid));
    endfunction

    // Lowest matching index wins.
    function automatic logic [IDX_W:0] first_hit(input logic [TLB_LINE_NUM-1:0] m);
        logic [IDX_W:0] r;
        r = '0;
        for (int i = TLB_LINE_NUM - 1; i >= 0; i--) begin
            if (m[i]) r = {1'b1, IDX_W'(i)};
        end
        return r;
    endfunction

    // Page size is 4K << popcount(mask); the bit just above the page offset selects even/odd.
    function automatic xlt_t xlate(input logic [31:0] va, input logic [11:0] mask,
                                   input logic [19:0] pfn0, input logic [2:0] c0, input logic d0, input logic v0,
                                   input logic [19:0] pfn1, input logic [2:0] c1, input logic d1, input logic v1);
        xlt_t r;
        logic [4:0]  sel_bit;
        logic [31:0] off_mask;
        sel_bit  = 5'd12 + 5'($countones(mask));
        off_mask = (32'd1 << sel_bit) - 32'd1;
        if (va[sel_bit]) r = '{paddr: {pfn1, 12'b0}, c: c1, d: d1, v: v1};
        else             r = '{paddr: {pfn0, 12'b0}, c: c0, d: d0, v: v0};
        r.paddr = (r.paddr & ~off_mask) | (va & off_mask);
        return r;
    endfunction

    function automatic port_t map_port(input logic [31:0] va, input logic wen, input logic hit,
                                       input xlt_t t, input logic [2:0] k0v);
        port_t r;
        r = '0;
        if (va[31:30] == 2'b10) begin
            r.paddr    = {3'b0, va[28:0]};
            r.uncached = va[29] | (k0v != 3'd3);
        end else begin
            r.refill   = ~hit;
            r.invalid  = hit & ~t.v;
            r.modified = hit & t.v & ~t.d & wen;
            r.uncached = ~hit | (t.c != 3'd3);
            r.paddr    = (r.refill | r.invalid | r.modified) ? 32'b0 : t.paddr;
        end
        return r;
    endfunction

    tlb_entry_t entry_reg [TLB_LINE_NUM];

    logic             wr_commit;
    logic [IDX_W-1:0] wr_idx;
    tlb_entry_t       wr_entry;

    assign wr_commit = (tlb_typeM[3] | tlb_typeM[2]) & ~stallM;
    assign wr_idx    = tlb_typeM[3] ? random_W[IDX_W-1:0] : index_W[IDX_W-1:0];
    assign wr_entry  = '{vpn2: entry_hi_W[31:13], asid: entry_hi_W[7:0], mask: page_mask_W[24:13],
                         g: entry_lo0_W[0] & entry_lo1_W[0],
                         pfn0: entry_lo0_W[25:6], c0: entry_lo0_W[5:3], d0: entry_lo0_W[2], v0: entry_lo0_W[1],
                         pfn1: entry_lo1_W[25:6], c1: entry_lo1_W[5:3], d1: entry_lo1_W[2], v1: entry_lo1_W[1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TLB_LINE_NUM; i++) entry_reg[i] <= '0;
        end else if (wr_commit) begin
            entry_reg[wr_idx] <= wr_entry;
        end
    end

    logic [TLB_LINE_NUM-1:0] match_inst, match_data, match_probe;

    for (genvar gi = 0; gi < TLB_LINE_NUM; gi++) begin : g_match
        assign match_inst[gi]  = entry_match(entry_reg[gi].vpn2, entry_reg[gi].mask, entry_reg[gi].g,
                                             entry_reg[gi].asid, inst_vaddr[31:13], entry_hi_W[7:0]);
        assign match_data[gi]  = entry_match(entry_reg[gi].vpn2, entry_reg[gi].mask, entry_reg[gi].g,
                                             entry_reg[gi].asid, data_vaddr[31:13], entry_hi_W[7:0]);
        assign match_probe[gi] = entry_match(entry_reg[gi].vpn2, entry_reg[gi].mask, entry_reg[gi].g,
                                             entry_reg[gi].asid, entry_hi_W[31:13], entry_hi_W[7:0]);
    end

    logic [IDX_W:0] inst_sel, data_sel, probe_sel;
    tlb_entry_t     inst_ent, data_ent, rd_ent;
    xlt_t           inst_xlt, data_xlt;
    port_t          inst_main, data_res;

    assign inst_sel  = first_hit(match_inst);
    assign data_sel  = first_hit(match_data);
    assign probe_sel = first_hit(match_probe);
    assign inst_ent  = entry_reg[inst_sel[IDX_W-1:0]];
    assign data_ent  = entry_reg[data_sel[IDX_W-1:0]];
    assign rd_ent    = entry_reg[index_W[IDX_W-1:0]];

    assign inst_xlt  = xlate(inst_vaddr, inst_ent.mask, inst_ent.pfn0, inst_ent.c0, inst_ent.d0, inst_ent.v0,
                             inst_ent.pfn1, inst_ent.c1, inst_ent.d1, inst_ent.v1);
    assign data_xlt  = xlate(data_vaddr, data_ent.mask, data_ent.pfn0, data_ent.c0, data_ent.d0, data_ent.v0,
                             data_ent.pfn1, data_ent.c1, data_ent.d1, data_ent.v1);
    assign inst_main = map_port(inst_vaddr, 1'b0, inst_sel[IDX_W], inst_xlt, k0);
    assign data_res  = map_port(data_vaddr, data_wen, data_sel[IDX_W], data_xlt, k0);

    assign data_paddr    = data_res.paddr;
    assign data_refill   = data_res.refill;
    assign data_invalid  = data_res.invalid;
    assign data_modified = data_res.modified;
    assign data_uncached = data_res.uncached;

    assign index_in     = probe_sel[IDX_W] ? 32'(probe_sel[IDX_W-1:0]) : 32'h8000_0000;
    assign entry_hi_in  = {rd_ent.vpn2, 5'b0, rd_ent.asid};
    assign page_mask_in = {7'b0, rd_ent.mask, 13'b0};
    assign entry_lo0_in = {6'b0, rd_ent.pfn0, rd_ent.c0, rd_ent.d0, rd_ent.v0, rd_ent.g};
    assign entry_lo1_in = {6'b0, rd_ent.pfn1, rd_ent.c1, rd_ent.d1, rd_ent.v1, rd_ent.g};

`ifdef ITLB_MICRO_EN
    typedef enum logic {UT_LOOKUP, UT_EXC} ut_state_t;

    ut_state_t   ut_state_reg, ut_state_next;
    logic        utlb_valid_reg, utlb_valid_next;
    logic [19:0] utlb_vpn_reg, utlb_vpn_next;
    logic [7:0]  utlb_asid_reg, utlb_asid_next;
    logic [19:0] utlb_pfn_reg, utlb_pfn_next;
    logic        utlb_unc_reg, utlb_unc_next;
    logic        exc_refill_reg, exc_refill_next;
    logic        exc_invalid_reg, exc_invalid_next;
    logic        exc_unc_reg, exc_unc_next;
    logic        utlb_hit;

    assign utlb_hit = utlb_valid_reg && (utlb_vpn_reg == inst_vaddr[31:12])
                      && (utlb_asid_reg == entry_hi_W[7:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            ut_state_reg    <= UT_LOOKUP;
            utlb_valid_reg  <= 1'b0;
            utlb_vpn_reg    <= '0;
            utlb_asid_reg   <= '0;
            utlb_pfn_reg    <= '0;
            utlb_unc_reg    <= 1'b0;
            exc_refill_reg  <= 1'b0;
            exc_invalid_reg <= 1'b0;
            exc_unc_reg     <= 1'b0;
        end else begin
            ut_state_reg    <= ut_state_next;
            utlb_valid_reg  <= utlb_valid_next;
            utlb_vpn_reg    <= utlb_vpn_next;
            utlb_asid_reg   <= utlb_asid_next;
            utlb_pfn_reg    <= utlb_pfn_next;
            utlb_unc_reg    <= utlb_unc_next;
            exc_refill_reg  <= exc_refill_next;
            exc_invalid_reg <= exc_invalid_next;
            exc_unc_reg     <= exc_unc_next;
        end
    end

    always_comb begin
        ut_state_next    = ut_state_reg;
        utlb_valid_next  = utlb_valid_reg;
        utlb_vpn_next    = utlb_vpn_reg;
        utlb_asid_next   = utlb_asid_reg;
        utlb_pfn_next    = utlb_pfn_reg;
        utlb_unc_next    = utlb_unc_reg;
        exc_refill_next  = exc_refill_reg;
        exc_invalid_next = exc_invalid_reg;
        exc_unc_next     = exc_unc_reg;
        inst_paddr       = 32'b0;
        inst_refill      = 1'b0;
        inst_invalid     = 1'b0;
        inst_uncached    = 1'b0;
        inst_tlb_stall   = 1'b0;
        if (ut_state_reg == UT_EXC) begin
            // Report the exception captured on the preceding miss cycle.
            inst_refill   = exc_refill_reg;
            inst_invalid  = exc_invalid_reg;
            inst_uncached = exc_unc_reg;
            ut_state_next = UT_LOOKUP;
        end else if (inst_vaddr[31:30] == 2'b10) begin
            inst_paddr    = inst_main.paddr;
            inst_uncached = inst_main.uncached;
        end else if (utlb_hit) begin
            inst_paddr    = {utlb_pfn_reg, inst_vaddr[11:0]};
            inst_uncached = utlb_unc_reg;
        end else begin
            inst_tlb_stall = 1'b1;
            if (inst_main.refill | inst_main.invalid) begin
                exc_refill_next  = inst_main.refill;
                exc_invalid_next = inst_main.invalid;
                exc_unc_next     = inst_main.uncached;
                ut_state_next    = UT_EXC;
            end else begin
                utlb_valid_next = 1'b1;
                utlb_vpn_next   = inst_vaddr[31:12];
                utlb_asid_next  = entry_hi_W[7:0];
                utlb_pfn_next   = inst_main.paddr[31:12];
                utlb_unc_next   = inst_main.uncached;
            end
        end
        if (wr_commit) utlb_valid_next = 1'b0;
    end

    logic unused_micro;
    assign unused_micro = ^inst_main.paddr[11:0];
`else
    assign inst_paddr     = inst_main.paddr;
    assign inst_refill    = inst_main.refill;
    assign inst_invalid   = inst_main.invalid;
    assign inst_uncached  = inst_main.uncached;
    assign inst_tlb_stall = 1'b0;
`endif

    logic unused_bits;
    assign unused_bits = ^{tlb_typeM[1:0], entry_hi_W[12:8], page_mask_W[31:25], page_mask_W[12:0],
                           entry_lo0_W[31:26], entry_lo1_W[31:26], index_W[31:IDX_W],
                           random_W[31:IDX_W], inst_main.modified};
endmodule

// File: tb/tb_tlb_unit.sv
// Scoreboard bench for tlb_unit: expectations are queued as stimulus is applied and checked on sampling.
module tb_tlb_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        stallM;
    logic [3:0]  tlb_typeM;
    logic [31:0] entry_hi_W, page_mask_W, entry_lo0_W, entry_lo1_W, index_W, random_W;
    logic [2:0]  k0;
    logic [31:0] index_in, entry_hi_in, page_mask_in, entry_lo0_in, entry_lo1_in;
    logic [31:0] inst_vaddr, inst_paddr;
    logic        inst_refill, inst_invalid, inst_uncached, inst_tlb_stall;
    logic [31:0] data_vaddr, data_paddr;
    logic        data_wen, data_refill, data_invalid, data_modified, data_uncached;

    always #5 clk = ~clk;

    tlb_unit #(.TLB_LINE_NUM(16)) dut (
        .clk(clk), .rst(rst), .stallM(stallM), .tlb_typeM(tlb_typeM),
        .entry_hi_W(entry_hi_W), .page_mask_W(page_mask_W), .entry_lo0_W(entry_lo0_W),
        .entry_lo1_W(entry_lo1_W), .index_W(index_W), .random_W(random_W), .k0(k0),
        .index_in(index_in), .entry_hi_in(entry_hi_in), .page_mask_in(page_mask_in),
        .entry_lo0_in(entry_lo0_in), .entry_lo1_in(entry_lo1_in),
        .inst_vaddr(inst_vaddr), .inst_paddr(inst_paddr), .inst_refill(inst_refill),
        .inst_invalid(inst_invalid), .inst_uncached(inst_uncached), .inst_tlb_stall(inst_tlb_stall),
        .data_vaddr(data_vaddr), .data_wen(data_wen), .data_paddr(data_paddr),
        .data_refill(data_refill), .data_invalid(data_invalid), .data_modified(data_modified),
        .data_uncached(data_uncached)
    );

    localparam int S_DPA = 0, S_DRF = 1, S_DINV = 2, S_DMOD = 3, S_DUNC = 4;
    localparam int S_IPA = 5, S_IRF = 6, S_IINV = 7, S_IUNC = 8, S_STALL = 9;
    localparam int S_IDX = 10, S_EHI = 11, S_PM = 12, S_LO0 = 13, S_LO1 = 14;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_DPA:   return data_paddr;
            S_DRF:   return 32'(data_refill);
            S_DINV:  return 32'(data_invalid);
            S_DMOD:  return 32'(data_modified);
            S_DUNC:  return 32'(data_uncached);
            S_IPA:   return inst_paddr;
            S_IRF:   return 32'(inst_refill);
            S_IINV:  return 32'(inst_invalid);
            S_IUNC:  return 32'(inst_uncached);
            S_STALL: return 32'(inst_tlb_stall);
            S_IDX:   return index_in;
            S_EHI:   return entry_hi_in;
            S_PM:    return page_mask_in;
            S_LO0:   return entry_lo0_in;
            default: return entry_lo1_in;
        endcase
    endfunction

    task automatic expect_out(input string tag, input int sel, input logic [31:0] v);
        sb_q.push_back('{tag, sel, v});
    endtask

    task automatic sample();
        exp_t e;
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val(e.tag, observe(e.sel), e.exp);
        end
    endtask

    // unc < 0 leaves the cacheability of a refilling access unchecked.
    task automatic data_look(input string tag, input logic [31:0] va, input logic wen,
                             input logic [31:0] pa, input logic rf, input logic inv,
                             input logic md, input int unc);
        data_vaddr = va;
        data_wen   = wen;
        expect_out({tag, ".paddr"}, S_DPA, pa);
        expect_out({tag, ".refill"}, S_DRF, 32'(rf));
        expect_out({tag, ".invalid"}, S_DINV, 32'(inv));
        expect_out({tag, ".modified"}, S_DMOD, 32'(md));
        if (unc >= 0) expect_out({tag, ".uncached"}, S_DUNC, 32'(unc));
        sample();
    endtask

    task automatic tlb_write(input logic [3:0] typ, input logic [31:0] idx, input logic [31:0] ehi,
                             input logic [31:0] pm, input logic [31:0] lo0, input logic [31:0] lo1);
        @(negedge clk);
        tlb_typeM   = typ;
        index_W     = idx;
        random_W    = idx;
        entry_hi_W  = ehi;
        page_mask_W = pm;
        entry_lo0_W = lo0;
        entry_lo1_W = lo1;
        @(posedge clk);
        @(negedge clk);
        tlb_typeM = 4'b0000;
    endtask

    initial begin
        rst = 1'b1; stallM = 1'b0; tlb_typeM = 4'b0;
        entry_hi_W = 32'h0040_0005; page_mask_W = 32'b0; entry_lo0_W = 32'b0; entry_lo1_W = 32'b0;
        index_W = 32'b0; random_W = 32'b0; k0 = 3'd3;
        inst_vaddr = 32'hBFC0_0000; data_vaddr = 32'b0; data_wen = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        expect_out("rst.index_in", S_IDX, 32'h8000_0000);
        expect_out("rst.entry_hi_in", S_EHI, 32'h0);
        expect_out("rst.page_mask_in", S_PM, 32'h0);
        expect_out("rst.entry_lo0_in", S_LO0, 32'h0);
        expect_out("rst.entry_lo1_in", S_LO1, 32'h0);
        expect_out("rst.stall", S_STALL, 32'h0);
        expect_out("rst.inst_paddr", S_IPA, 32'h1FC0_0000);
        expect_out("rst.inst_uncached", S_IUNC, 32'h1);
        sample();
        entry_hi_W = 32'h0;
        data_look("rst_data", 32'h0040_0000, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, -1);

        // tlbwi entry 3; a lookup in the write cycle still sees the empty entry.
        @(negedge clk);
        entry_hi_W = 32'h0040_0005; page_mask_W = 32'h0;
        entry_lo0_W = 32'h0000_401E; entry_lo1_W = 32'h0000_0018; index_W = 32'd3;
        tlb_typeM = 4'b0100;
        data_look("wi_same_cycle", 32'h0040_0123, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, -1);
        @(posedge clk);
        @(negedge clk);
        tlb_typeM = 4'b0000;
        data_look("map_even", 32'h0040_0123, 1'b0, 32'h0010_0123, 1'b0, 1'b0, 1'b0, 0);
        data_look("map_odd_inv", 32'h0040_1000, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 0);

        tlb_write(4'b0100, 32'd3, 32'h0040_0005, 32'h0, 32'h0000_401A, 32'h0000_0018);
        data_look("mod_store", 32'h0040_0123, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 0);
        data_look("mod_load", 32'h0040_0123, 1'b0, 32'h0010_0123, 1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
        entry_hi_W = 32'h0040_0006;
        data_look("asid_miss", 32'h0040_0123, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, -1);

        @(negedge clk);
        k0 = 3'd2;
        data_look("kseg0_unc", 32'h8000_1234, 1'b1, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 1);
        k0 = 3'd3;
        data_look("kseg0_cached", 32'h8000_1234, 1'b0, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
        data_look("kseg1", 32'hA000_2000, 1'b1, 32'h0000_2000, 1'b0, 1'b0, 1'b0, 1);

        // TLBP hit/miss and TLBR of entry 3.
        @(negedge clk);
        entry_hi_W = 32'h0040_0005; index_W = 32'd3;
        expect_out("tlbp_hit", S_IDX, 32'd3);
        expect_out("tlbr3.entry_hi", S_EHI, 32'h0040_0005);
        expect_out("tlbr3.page_mask", S_PM, 32'h0);
        expect_out("tlbr3.lo0", S_LO0, 32'h0000_401A);
        expect_out("tlbr3.lo1", S_LO1, 32'h0000_0018);
        sample();
        entry_hi_W = 32'h0060_0005;
        expect_out("tlbp_miss", S_IDX, 32'h8000_0000);
        sample();

        // tlbwr into entry 7 held off by two stalled cycles.
        @(negedge clk);
        entry_hi_W = 32'h0080_0005; page_mask_W = 32'h0;
        entry_lo0_W = 32'h0000_8016; entry_lo1_W = 32'h0; random_W = 32'd7; index_W = 32'd7;
        tlb_typeM = 4'b1000; stallM = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        data_look("wr_stalled", 32'h0080_0010, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, -1);
        expect_out("wr_stalled.tlbr7", S_EHI, 32'h0);
        sample();
        stallM = 1'b0;
        data_look("wr_write_cycle", 32'h0080_0010, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, -1);
        @(posedge clk);
        @(negedge clk);
        tlb_typeM = 4'b0000;
        data_look("wr_done", 32'h0080_0010, 1'b0, 32'h0020_0010, 1'b0, 1'b0, 1'b0, 1);
        expect_out("wr_done.tlbr7", S_EHI, 32'h0080_0005);
        sample();

        // Duplicate mapping in entry 9: entry 3 still wins.
        tlb_write(4'b0100, 32'd9, 32'h0040_0005, 32'h0, 32'h0000_C01E, 32'h0000_0018);
        index_W = 32'd3;
        expect_out("dup_tlbp", S_IDX, 32'd3);
        sample();
        data_look("dup_lookup", 32'h0040_0123, 1'b0, 32'h0010_0123, 1'b0, 1'b0, 1'b0, 0);

        // 16K page pair in entry 10: odd/even on bit 14, 14-bit offset.
        tlb_write(4'b0100, 32'd10, 32'h0200_0005, 32'h0000_6000, 32'h0000_0018, 32'h0001_401E);
        data_look("big_odd", 32'h0200_4567, 1'b0, 32'h0050_0567, 1'b0, 1'b0, 1'b0, 0);
        data_look("big_even_inv", 32'h0200_1000, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 0);
        @(negedge clk);
        expect_out("tlbr10.page_mask", S_PM, 32'h0000_6000);
        expect_out("tlbr10.entry_hi", S_EHI, 32'h0200_0005);
        sample();

        // Global entry 11 matches under a different ASID.
        tlb_write(4'b0100, 32'd11, 32'h0100_0007, 32'h0, 32'h0000_401F, 32'h0000_0019);
        entry_hi_W = 32'h0100_0006;
        data_look("global", 32'h0100_0040, 1'b0, 32'h0010_0040, 1'b0, 1'b0, 1'b0, 0);
        expect_out("tlbr11.lo0", S_LO0, 32'h0000_401F);
        expect_out("tlbr11.lo1", S_LO1, 32'h0000_0019);
        sample();

        @(negedge clk);
        entry_hi_W = 32'h0040_0005;
        inst_vaddr = 32'h0040_0123;
`ifdef ITLB_MICRO_EN
        expect_out("ifetch_miss.stall", S_STALL, 32'h1);
        sample();
        @(negedge clk);
        expect_out("ifetch_hit.stall", S_STALL, 32'h0);
        expect_out("ifetch_hit.paddr", S_IPA, 32'h0010_0123);
        sample();
        tlb_write(4'b0100, 32'd3, 32'h0040_0005, 32'h0, 32'h0000_401A, 32'h0000_0018);
        expect_out("ifetch_after_wi.stall", S_STALL, 32'h1);
        sample();
        @(negedge clk);
        expect_out("ifetch_refilled.stall", S_STALL, 32'h0);
        expect_out("ifetch_refilled.paddr", S_IPA, 32'h0010_0123);
        sample();
        @(negedge clk);
        inst_vaddr = 32'h00C0_0000;
        expect_out("ifetch_exc.stall", S_STALL, 32'h1);
        sample();
        @(negedge clk);
        expect_out("ifetch_exc_rep.refill", S_IRF, 32'h1);
        expect_out("ifetch_exc_rep.stall", S_STALL, 32'h0);
        expect_out("ifetch_exc_rep.paddr", S_IPA, 32'h0);
        sample();
`else
        expect_out("ifetch.stall", S_STALL, 32'h0);
        expect_out("ifetch.paddr", S_IPA, 32'h0010_0123);
        expect_out("ifetch.refill", S_IRF, 32'h0);
        expect_out("ifetch.uncached", S_IUNC, 32'h0);
        sample();
        @(negedge clk);
        inst_vaddr = 32'h00C0_0000;
        expect_out("ifetch_miss.refill", S_IRF, 32'h1);
        expect_out("ifetch_miss.invalid", S_IINV, 32'h0);
        expect_out("ifetch_miss.paddr", S_IPA, 32'h0);
        sample();
`endif
        @(negedge clk);
        inst_vaddr = 32'hBFC0_0000;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
